hd44780_ram_reader: RTL
=======================

// Module: hd44780_ram_reader
// PURPOSE
//  Read side of the hd44780_ram display buffer. Reads a run of bytes from the RAM read port and
//  presents them one at a time on a valid/ready byte interface to the HD44780 nybble/bus driver.
//  Sits between the dual-port buffer, which is filled by the host/writer, and the LCD driver.
// PARAMETERS
//  addr_width  9  RAM address bits (512-entry buffer)
//  data_width  8  RAM word / LCD byte width
// PORTS
//  clk         in   1             system clock; RAM rclk uses the same clock
//  rst_n       in   1             asynchronous active-low reset
//  start       in   1             1-cycle pulse that begins a transfer; sampled only in IDLE
//  start_addr  in   addr_width    first RAM address of the run
//  length      in   addr_width+1  number of bytes (0..2^addr_width)
//  rs_in       in   1             RS for the run (1=data, 0=command); latched at start
//  busy        out  1             high from the cycle after an accepted start until done
//  done        out  1             1-cycle pulse when the run completes
//  ram_raddr   out  addr_width    registered RAM read address
//  ram_dout    in   data_width    RAM read data; valid 1 clk after ram_raddr is stable at an edge
//  lcd_byte    out  data_width    byte to the LCD driver
//  lcd_rs      out  1             RS for lcd_byte
//  lcd_valid   out  1             lcd_byte/lcd_rs are valid
//  lcd_ready   in   1             driver accepts the byte when lcd_valid && lcd_ready at a rising edge
// BEHAVIOUR
//  - Reset (async, rst_n=0): state IDLE; busy=0, done=0, lcd_valid=0, lcd_byte=0, lcd_rs=0,
//    ram_raddr=0; internal address/count cleared. Reset mid-run aborts the run; no done pulse.
//  - FSM: IDLE -> ADDR -> WAIT -> CAPT -> PRESENT -> (ADDR | FINISH) -> IDLE.
//    IDLE: on start, latch start_addr, length, rs_in. If length==0, go to FINISH. Otherwise go to ADDR.
//    ADDR: drive ram_raddr=cur_addr.
//    WAIT: one cycle for RAM read latency.
//    CAPT: register ram_dout into lcd_byte and drive lcd_rs. Set lcd_valid=1.
//    PRESENT: hold lcd_byte/lcd_rs/lcd_valid stable until handshake. On handshake:
//      lcd_valid=0, cur_addr+=1, remaining-=1. Go to FINISH if remaining becomes 0, else ADDR.
//    FINISH: done=1 for exactly one cycle, busy=0, then IDLE.
//  - Throughput: one byte per 4 clks with lcd_ready tied high. First lcd_valid appears 4 clks after
//    the start edge.
//  - Address is modulo 2^addr_width: 0x1FF increments to 0x000. length=2^addr_width reads the whole
//    RAM once.
//  - start while busy is ignored. No RAM writes are issued, ever.
//  - lcd_valid never drops without a handshake, except on reset.
// CONFIGURATION
//  HD44780_RAM_READER_ESC_EN defined: byte 0xFE is an escape and is not presented. The next byte
//    is presented with lcd_rs=0, and RS reverts to rs_in afterwards. Both bytes count toward length.
//    A trailing 0xFE as the last byte is dropped; done is still pulsed. 0xFE 0xFE presents 0xFE with rs=0.
//  HD44780_RAM_READER_ESC_EN undefined: every byte is presented verbatim with lcd_rs=rs_in.
// TESTING
//  1 RAM[0x06D..0x06F]=48,49,21; start addr 0x06D, len 3, rs_in=1, ready=1
//    -> bytes 48,49,21 with rs=1; one done pulse; busy low after.
//  2 As 1, ready low for 5 clks while byte 49 is valid
//    -> lcd_byte=49 and lcd_rs held stable; ram_raddr stays 0x06E; sequence then completes.
//  3 start addr 0x1FF, len 2, RAM[0x1FF]=A5, RAM[0x000]=5A
//    -> ram_raddr goes 0x1FF then 0x000; bytes A5 then 5A.
//  4 len 0 -> done pulses 2 clks after the start edge; lcd_valid never asserted; no RAM address change.
//  5 Deassert rst_n while lcd_valid=1 mid-run
//    -> all outputs 0 immediately; no done; a fresh start then runs correctly.
//  6 RAM=FE,01,41; len 3; rs_in=1
//    -> with ESC_EN: 01 (rs=0) then 41 (rs=1). Without ESC_EN: FE,01,41 all with rs=1.

Source files
------------

// File: rtl/hd44780_ram_reader.sv
// hd44780_ram_reader: read side of the hd44780_ram display buffer.
// Fetches a run of bytes from the synchronous RAM read port and hands them to the
// HD44780 bus driver over a valid/ready byte interface, one byte per handshake.
// Optional feature: define HD44780_RAM_READER_ESC_EN so that byte 0xFE acts as an escape.
// The byte after the escape is presented as a command (lcd_rs=0).

module hd44780_ram_reader #(
   parameter int unsigned addr_width = 9,
   parameter int unsigned data_width = 8
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic [addr_width-1:0] start_addr,
   input  logic [addr_width:0]   length,
   input  logic                  rs_in,
   output logic                  busy,
   output logic                  done,
   output logic [addr_width-1:0] ram_raddr,
   input  logic [data_width-1:0] ram_dout,
   output logic [data_width-1:0] lcd_byte,
   output logic                  lcd_rs,
   output logic                  lcd_valid,
   input  logic                  lcd_ready
);

   typedef enum logic [2:0] {
      StIdle,
      StAddr,
      StWait,
      StCapt,
      StPresent,
      StFinish
   } state_e;

   localparam logic [addr_width:0]   ZeroCnt = '0;
   localparam logic [addr_width:0]   OneCnt  = (addr_width+1)'(1);
   localparam logic [addr_width-1:0] OneAddr = addr_width'(1);

`ifdef HD44780_RAM_READER_ESC_EN
   localparam logic [data_width-1:0] EscByte = data_width'(8'hFE);
   logic esc_q;   // previous byte was an escape; next presented byte is a command
`endif

   state_e                state_q;
   logic [addr_width-1:0] cur_addr_q;
   logic [addr_width:0]   remaining_q;
   logic                  rs_q;

   // Single-process FSM; every output is a register updated here.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= StIdle;
         cur_addr_q  <= '0;
         remaining_q <= '0;
         rs_q        <= 1'b0;
         busy        <= 1'b0;
         done        <= 1'b0;
         ram_raddr   <= '0;
         lcd_byte    <= '0;
         lcd_rs      <= 1'b0;
         lcd_valid   <= 1'b0;
`ifdef HD44780_RAM_READER_ESC_EN
         esc_q       <= 1'b0;
`endif
      end else begin
         done <= 1'b0;
         unique case (state_q)
            StIdle: begin
               if (start) begin
                  cur_addr_q  <= start_addr;
                  remaining_q <= length;
                  rs_q        <= rs_in;
                  busy        <= 1'b1;
`ifdef HD44780_RAM_READER_ESC_EN
                  esc_q       <= 1'b0;
`endif
                  state_q     <= (length == ZeroCnt) ? StFinish : StAddr;
               end
            end
            StAddr: begin
               ram_raddr <= cur_addr_q;
               state_q   <= StWait;
            end
            // RAM samples ram_raddr on this edge; data is on ram_dout in CAPT
            StWait: state_q <= StCapt;
            StCapt: begin
`ifdef HD44780_RAM_READER_ESC_EN
               if (!esc_q && ram_dout == EscByte) begin
                  // Swallow the escape; it still consumes one byte of the run
                  esc_q       <= 1'b1;
                  cur_addr_q  <= cur_addr_q + OneAddr;
                  remaining_q <= remaining_q - OneCnt;
                  state_q     <= (remaining_q == OneCnt) ? StFinish : StAddr;
               end else begin
                  lcd_byte  <= ram_dout;
                  lcd_rs    <= rs_q & ~esc_q;
                  lcd_valid <= 1'b1;
                  state_q   <= StPresent;
               end
`else
               lcd_byte  <= ram_dout;
               lcd_rs    <= rs_q;
               lcd_valid <= 1'b1;
               state_q   <= StPresent;
`endif
            end
            StPresent: begin
               if (lcd_ready) begin
                  lcd_valid   <= 1'b0;
                  cur_addr_q  <= cur_addr_q + OneAddr;
                  remaining_q <= remaining_q - OneCnt;
`ifdef HD44780_RAM_READER_ESC_EN
                  esc_q       <= 1'b0;
`endif
                  state_q     <= (remaining_q == OneCnt) ? StFinish : StAddr;
               end
            end
            StFinish: begin
               done    <= 1'b1;
               busy    <= 1'b0;
`ifdef HD44780_RAM_READER_ESC_EN
               esc_q   <= 1'b0;
`endif
               state_q <= StIdle;
            end
            default: state_q <= StIdle;
         endcase
      end
   end

endmodule
